// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between instruction fetch and memory access.
// One transaction in flight; MA has priority with a starvation guard for IF.
module mem_port_arbiter #(
    parameter int DATA_SIZE    = 32,
    parameter int ADDR_SIZE    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_if_req,
    input  logic [ADDR_SIZE-1:0] i_if_addr,
    input  logic                 i_if_kill,
    output logic                 o_if_gnt,
    output logic                 o_if_rvalid,
    output logic [DATA_SIZE-1:0] o_if_rdata,
    input  logic                 i_ma_req,
    input  logic                 i_ma_we,
    input  logic [ADDR_SIZE-1:0] i_ma_addr,
    input  logic [DATA_SIZE-1:0] i_ma_wdata,
    input  logic [3:0]           i_ma_be,
    output logic                 o_ma_gnt,
    output logic                 o_ma_rvalid,
    output logic [DATA_SIZE-1:0] o_ma_rdata,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [ADDR_SIZE-1:0] o_mem_addr,
    output logic [DATA_SIZE-1:0] o_mem_wdata,
    output logic [3:0]           o_mem_be,
    input  logic                 i_mem_gnt,
    input  logic                 i_mem_rvalid,
    input  logic [DATA_SIZE-1:0] i_mem_rdata,
    output logic                 o_busy
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt;
    logic       killed;
    logic       owner_if;
    logic       if_win;

    // IF only beats a pending MA request once MA has used up its streak.
    assign if_win = i_if_req && (!i_ma_req || starve_cnt == LIMIT);

    always_comb begin
        state_nxt = state;
        o_if_gnt  = 1'b0;
        o_ma_gnt  = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    o_if_gnt = if_win;
                    o_ma_gnt = i_ma_req && !if_win;
                    if (if_win || i_ma_req)
                        state_nxt = REQ;
                end
            end
            REQ:     if (i_mem_gnt)    state_nxt = RESP;
            RESP:    if (i_mem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_mem_req = (state == REQ);
    assign o_busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            killed      <= 1'b0;
            owner_if    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_be    <= '0;
            o_if_rvalid <= 1'b0;
            o_ma_rvalid <= 1'b0;
            o_if_rdata  <= '0;
            o_ma_rdata  <= '0;
        end else begin
            state       <= state_nxt;
            o_if_rvalid <= 1'b0;
            o_ma_rvalid <= 1'b0;

            if (!i_if_req || o_if_gnt)
                starve_cnt <= '0;
            else if (o_ma_gnt && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;

            if (o_if_gnt) begin
                owner_if    <= 1'b1;
                killed      <= 1'b0;
                o_mem_we    <= 1'b0;
                o_mem_addr  <= i_if_addr;
                o_mem_wdata <= '0;
                o_mem_be    <= 4'hF;
            end else if (o_ma_gnt) begin
                owner_if    <= 1'b0;
                killed      <= 1'b0;
                o_mem_we    <= i_ma_we;
                o_mem_addr  <= i_ma_addr;
                o_mem_wdata <= i_ma_wdata;
                o_mem_be    <= i_ma_be;
            end

            if ((state == REQ || state == RESP) && owner_if && i_if_kill)
                killed <= 1'b1;

            // Memory cannot be cancelled, so a killed fetch still runs to completion.
            if (state == RESP && i_mem_rvalid) begin
                killed <= 1'b0;
                if (owner_if) begin
                    if (!(killed || i_if_kill)) begin
                        o_if_rvalid <= 1'b1;
                        o_if_rdata  <= i_mem_rdata;
                    end
                end else begin
                    o_ma_rvalid <= 1'b1;
                    o_ma_rdata  <= o_mem_we ? '0 : i_mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_if_req, i_if_kill, i_ma_req, i_ma_we, i_mem_gnt, i_mem_rvalid;
    logic [31:0] i_if_addr, i_ma_addr, i_ma_wdata, i_mem_rdata;
    logic [3:0]  i_ma_be;
    logic        o_if_gnt, o_if_rvalid, o_ma_gnt, o_ma_rvalid, o_mem_req, o_mem_we, o_busy;
    logic [31:0] o_if_rdata, o_ma_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_SIZE(32), .ADDR_SIZE(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_kill(i_if_kill),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_ma_req(i_ma_req), .i_ma_we(i_ma_we), .i_ma_addr(i_ma_addr),
        .i_ma_wdata(i_ma_wdata), .i_ma_be(i_ma_be),
        .o_ma_gnt(o_ma_gnt), .o_ma_rvalid(o_ma_rvalid), .o_ma_rdata(o_ma_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_busy(o_busy)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one transaction in flight, issued then answered.
    bit          armed = 1'b0;
    bit          m_active = 1'b0, m_issued = 1'b0, m_owner_if = 1'b0, m_killed = 1'b0;
    bit          m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_be = '0;
    int          m_starve = 0;
    bit          m_if_rv = 1'b0, m_ma_rv = 1'b0;
    logic [31:0] m_if_rd = '0, m_ma_rd = '0;
    bit          ev_if_gnt = 1'b0, ev_ma_gnt = 1'b0;

    function automatic bit pred_if_gnt();
        return !rst && !m_active && i_if_req && (!i_ma_req || m_starve == LIMIT);
    endfunction

    function automatic bit pred_ma_gnt();
        return !rst && !m_active && i_ma_req && !pred_if_gnt();
    endfunction

    always @(posedge clk) begin : model
        bit ig, mg, kill_now;
        ig = pred_if_gnt();
        mg = pred_ma_gnt();
        ev_if_gnt = ig;
        ev_ma_gnt = mg;
        if (rst) begin
            armed = 1'b1;
            m_active = 0; m_issued = 0; m_owner_if = 0; m_killed = 0;
            m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0; m_starve = 0;
            m_if_rv = 0; m_ma_rv = 0; m_if_rd = '0; m_ma_rd = '0;
        end else begin
            m_if_rv = 0;
            m_ma_rv = 0;
            if (!m_active) begin
                if (ig || mg) begin
                    m_active = 1; m_issued = 0; m_owner_if = ig; m_killed = 0;
                    m_we    = ig ? 1'b0  : i_ma_we;
                    m_addr  = ig ? i_if_addr : i_ma_addr;
                    m_wdata = ig ? 32'h0 : i_ma_wdata;
                    m_be    = ig ? 4'hF  : i_ma_be;
                end
            end else if (!m_issued) begin
                if (m_owner_if && i_if_kill) m_killed = 1;
                if (i_mem_gnt) m_issued = 1;
            end else begin
                kill_now = m_killed || (m_owner_if && i_if_kill);
                if (i_mem_rvalid) begin
                    m_active = 0;
                    if (m_owner_if) begin
                        if (!kill_now) begin m_if_rv = 1; m_if_rd = i_mem_rdata; end
                    end else begin
                        m_ma_rv = 1;
                        m_ma_rd = m_we ? 32'h0 : i_mem_rdata;
                    end
                end else begin
                    m_killed = kill_now;
                end
            end
            if (!i_if_req || ig)  m_starve = 0;
            else if (mg)          m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk1("m_if_gnt", o_if_gnt, pred_if_gnt());
            chk1("m_ma_gnt", o_ma_gnt, pred_ma_gnt());
            chk1("m_mem_req", o_mem_req, m_active && !m_issued);
            chk1("m_busy", o_busy, m_active);
            chk1("m_if_rvalid", o_if_rvalid, m_if_rv);
            chk1("m_ma_rvalid", o_ma_rvalid, m_ma_rv);
            if (m_if_rv) chk32("m_if_rdata", o_if_rdata, m_if_rd);
            if (m_ma_rv) chk32("m_ma_rdata", o_ma_rdata, m_ma_rd);
            chk1("m_mem_we", o_mem_we, m_we);
            chk32("m_mem_addr", o_mem_addr, m_addr);
            chk32("m_mem_wdata", o_mem_wdata, m_wdata);
            chk32("m_mem_be", 32'(o_mem_be), 32'(m_be));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait memory: gnt in the first REQ cycle, rvalid the cycle after.
    task automatic mem_serve(input bit drop_if, input bit drop_ma, input logic [31:0] rd);
        step();
        if (drop_if) i_if_req = 1'b0;
        if (drop_ma) i_ma_req = 1'b0;
        i_if_kill = 1'b0;
        i_mem_gnt = 1'b1;
        step();
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = rd;
        step();
        i_mem_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_if_req = 1'b1; i_if_addr = 32'h100; i_if_kill = 1'b0;
        i_ma_req = 1'b0; i_ma_we = 1'b0; i_ma_addr = '0; i_ma_wdata = '0; i_ma_be = '0;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_if_gnt", o_if_gnt, 1'b0);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_mem_req", o_mem_req, 1'b0);
        chk32("rst_mem_addr", o_mem_addr, 32'h0);

        // Single IF read, zero-wait memory.
        step(); rst = 1'b0;
        @(negedge clk); chk1("t1_gnt_c0", o_if_gnt, 1'b1);
        step(); i_if_req = 1'b0; i_mem_gnt = 1'b1;
        @(negedge clk);
        chk1("t1_mem_req_c1", o_mem_req, 1'b1);
        chk32("t1_mem_addr_c1", o_mem_addr, 32'h100);
        chk32("t1_mem_be_c1", 32'(o_mem_be), 32'hF);
        step(); i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEADBEEF;
        @(negedge clk); chk1("t1_no_rvalid_c2", o_if_rvalid, 1'b0);
        step(); i_mem_rvalid = 1'b0;
        @(negedge clk);
        chk1("t1_rvalid_c3", o_if_rvalid, 1'b1);
        chk32("t1_rdata_c3", o_if_rdata, 32'hDEADBEEF);
        chk1("t1_idle_c3", o_busy, 1'b0);

        // Simultaneous requests: MA first, IF on the next IDLE entry.
        step();
        i_if_req = 1'b1; i_if_addr = 32'h300;
        i_ma_req = 1'b1; i_ma_we = 1'b0; i_ma_addr = 32'h400; i_ma_be = 4'hF;
        @(negedge clk);
        chk1("t2_ma_first", o_ma_gnt, 1'b1);
        chk1("t2_if_wait", o_if_gnt, 1'b0);
        mem_serve(1'b0, 1'b1, 32'h0000A5A5);
        @(negedge clk);
        chk1("t2_ma_rvalid", o_ma_rvalid, 1'b1);
        chk32("t2_ma_rdata", o_ma_rdata, 32'h0000A5A5);
        chk1("t2_if_next", o_if_gnt, 1'b1);
        mem_serve(1'b1, 1'b0, 32'h00001111);
        @(negedge clk);
        chk32("t2_if_rdata", o_if_rdata, 32'h00001111);

        // Starvation guard: four MA grants, then IF.
        step();
        i_if_req = 1'b1; i_if_addr = 32'h500;
        i_ma_req = 1'b1; i_ma_addr = 32'h600;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            chk1("t3_ma_gnt", o_ma_gnt, 1'b1);
            chk1("t3_if_held", o_if_gnt, 1'b0);
            mem_serve(1'b0, 1'b0, 32'(g));
        end
        @(negedge clk);
        chk1("t3_if_gnt", o_if_gnt, 1'b1);
        step(); i_ma_req = 1'b0;
        @(negedge clk);
        chk32("t3_starve_clr", 32'(dut.starve_cnt), 32'h0);
        i_if_req = 1'b0; i_mem_gnt = 1'b1;
        step(); i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5555;
        step(); i_mem_rvalid = 1'b0;

        // MA write with three wait cycles on the memory grant.
        step();
        i_ma_req = 1'b1; i_ma_we = 1'b1; i_ma_addr = 32'h200;
        i_ma_wdata = 32'h12345678; i_ma_be = 4'b0011;
        @(negedge clk); chk1("t4_gnt", o_ma_gnt, 1'b1);
        step();
        i_ma_req = 1'b0; i_ma_we = 1'b0; i_ma_addr = 32'hFFF; i_ma_wdata = '0; i_ma_be = 4'hF;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            @(negedge clk);
            chk1("t4_req_held", o_mem_req, 1'b1);
            chk1("t4_we_held", o_mem_we, 1'b1);
            chk32("t4_addr_held", o_mem_addr, 32'h200);
            chk32("t4_wdata_held", o_mem_wdata, 32'h12345678);
            chk32("t4_be_held", 32'(o_mem_be), 32'h3);
        end
        step(); i_mem_gnt = 1'b1;
        step(); i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hFFFFFFFF;
        step(); i_mem_rvalid = 1'b0;
        @(negedge clk);
        chk1("t4_ack", o_ma_rvalid, 1'b1);
        chk32("t4_ack_rdata", o_ma_rdata, 32'h0);

        // Kill while in RESP, then a normal fetch.
        step(); i_if_req = 1'b1; i_if_addr = 32'h600;
        @(negedge clk); chk1("t5_gnt", o_if_gnt, 1'b1);
        step(); i_if_req = 1'b0; i_mem_gnt = 1'b1;
        step(); i_mem_gnt = 1'b0; i_if_kill = 1'b1;
        step(); i_if_kill = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBAD0BAD0;
        step(); i_mem_rvalid = 1'b0;
        @(negedge clk);
        chk1("t5_killed", o_if_rvalid, 1'b0);
        chk1("t5_idle", o_busy, 1'b0);
        step(); i_if_req = 1'b1; i_if_addr = 32'h700;
        @(negedge clk); chk1("t5_next_gnt", o_if_gnt, 1'b1);
        mem_serve(1'b1, 1'b0, 32'h7777);
        @(negedge clk);
        chk1("t5_next_rvalid", o_if_rvalid, 1'b1);
        chk32("t5_next_rdata", o_if_rdata, 32'h7777);

        // Kill coinciding with the memory response.
        step(); i_if_req = 1'b1; i_if_addr = 32'h800;
        @(negedge clk); chk1("t5b_gnt", o_if_gnt, 1'b1);
        step(); i_if_req = 1'b0; i_mem_gnt = 1'b1;
        step(); i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_if_kill = 1'b1;
        step(); i_mem_rvalid = 1'b0; i_if_kill = 1'b0;
        @(negedge clk); chk1("t5b_suppressed", o_if_rvalid, 1'b0);

        // Kill in IDLE does not block a grant in the same cycle.
        step(); i_if_req = 1'b1; i_if_addr = 32'h880; i_if_kill = 1'b1;
        @(negedge clk); chk1("t5c_gnt", o_if_gnt, 1'b1);
        mem_serve(1'b1, 1'b0, 32'h8888);
        @(negedge clk); chk1("t5c_rvalid", o_if_rvalid, 1'b1);

        // Reset while in REQ, followed by a late response.
        step(); i_if_req = 1'b1; i_if_addr = 32'h900;
        @(negedge clk); chk1("t6_gnt", o_if_gnt, 1'b1);
        step(); i_if_req = 1'b0; rst = 1'b1;
        step(); rst = 1'b0; i_mem_rvalid = 1'b1; i_mem_gnt = 1'b1;
        @(negedge clk);
        chk1("t6_req_drop", o_mem_req, 1'b0);
        chk1("t6_busy_drop", o_busy, 1'b0);
        step(); i_mem_rvalid = 1'b0; i_mem_gnt = 1'b0;
        @(negedge clk);
        chk1("t6_no_if_rv", o_if_rvalid, 1'b0);
        chk1("t6_no_ma_rv", o_ma_rvalid, 1'b0);

        // Random traffic; requests held until granted, memory answers at random.
        repeat (3000) begin
            step();
            rst = ($urandom_range(0, 149) == 0);
            if (ev_if_gnt || !i_if_req) begin
                i_if_req  = ($urandom_range(0, 1) == 1);
                i_if_addr = $urandom;
            end
            if (ev_ma_gnt || !i_ma_req) begin
                i_ma_req   = ($urandom_range(0, 2) != 0);
                i_ma_we    = ($urandom_range(0, 1) == 1);
                i_ma_addr  = $urandom;
                i_ma_wdata = $urandom;
                i_ma_be    = 4'($urandom);
            end
            i_if_kill    = ($urandom_range(0, 7) == 0);
            i_mem_gnt    = ($urandom_range(0, 2) == 0);
            i_mem_rvalid = ($urandom_range(0, 2) == 0);
            i_mem_rdata  = $urandom;
        end

        step();
        rst = 1'b0; i_if_req = 1'b0; i_ma_req = 1'b0; i_if_kill = 1'b0;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
